sap_control_sequencer: RTL

//  Controller-sequencer: drives the ALU's enable (active-low output gate) and subtract lines, plus all other SAP control lines.

---
 rtl/sap_control_sequencer_pkg.sv | 56 +++++
 rtl/sap_control_sequencer_if.sv | 35 +++
 rtl/sap_control_sequencer_rom.sv | 85 ++++++++
 rtl/sap_control_sequencer.sv | 105 ++++++++++
 4 files changed

// File: rtl/sap_control_sequencer_pkg.sv
// Purpose: shared opcodes, control-word layout and T-state encoding for the SAP sequencer.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package sap_ctrl_pkg;

  // Opcodes (IR upper nibble)
  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_STA = 4'b0100;
  localparam logic [3:0] OP_LDI = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // Control-word bit indices
  localparam int unsigned CW_HLT     = 0;
  localparam int unsigned CW_MI      = 1;
  localparam int unsigned CW_RI      = 2;
  localparam int unsigned CW_RO      = 3;
  localparam int unsigned CW_II      = 4;
  localparam int unsigned CW_IO      = 5;
  localparam int unsigned CW_AI      = 6;
  localparam int unsigned CW_AO      = 7;
  localparam int unsigned CW_BI      = 8;
  localparam int unsigned CW_ALU_EN  = 9;
  localparam int unsigned CW_ALU_SUB = 10;
  localparam int unsigned CW_OI      = 11;
  localparam int unsigned CW_CE      = 12;
  localparam int unsigned CW_CO      = 13;
  localparam int unsigned CW_J       = 14;
  localparam int unsigned CW_FI      = 15;
  localparam int unsigned CW_W       = 16;

  typedef logic [CW_W-1:0] cw_t;

  // Idle word: alu_en is an active-low output gate, so "inactive" means 1.
  localparam cw_t CW_IDLE = cw_t'(1) << CW_ALU_EN;

  // T-states
  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } tstate_e;

  function automatic cw_t cw_bit(input int unsigned idx);
    return cw_t'(1) << idx;
  endfunction

endpackage

// File: rtl/sap_control_sequencer_if.sv
// Purpose: bundle between the sequencer and the IR/ALU/register datapath.
// Latency: n/a (wires only).
// Backpressure: none; control lines are level signals sampled every clock.
//  master: sequencer side (drives control lines, flags, step; reads opcode and ALU status)
//  slave : datapath side (drives opcode and ALU status; reads control lines)
interface sap_control_sequencer_if #(
  parameter int OPCODE_W = 4
);
  logic [OPCODE_W-1:0] opcode;
  logic                alu_carry;
  logic                alu_zero;

  logic hlt;
  logic mi, ri, ro;
  logic ii, io;
  logic ai, ao, bi;
  logic alu_en, alu_sub;
  logic oi, ce, co, j;
  logic fi;
  logic flag_c, flag_z;
  logic [2:0] step;

  modport master (
    input  opcode, alu_carry, alu_zero,
    output hlt, mi, ri, ro, ii, io, ai, ao, bi, alu_en, alu_sub,
           oi, ce, co, j, fi, flag_c, flag_z, step
  );

  modport slave (
    output opcode, alu_carry, alu_zero,
    input  hlt, mi, ri, ro, ii, io, ai, ao, bi, alu_en, alu_sub,
           oi, ce, co, j, fi, flag_c, flag_z, step
  );

endinterface

// File: rtl/sap_control_sequencer_rom.sv
// Purpose: combinational microcode: (opcode, T-state, flags) -> control word + last-step marker.
// Latency: 0 cycles (pure decode).
// Backpressure: none.
//  Ports: opcode, step, flag_c, flag_z in; cw (control word), last_step out.
module sap_microcode_rom
  import sap_ctrl_pkg::*;
#(
  parameter int OPCODE_W  = 4,
  parameter int STEPS     = 5,
  parameter bit EARLY_END = 1'b1
) (
  input  logic [OPCODE_W-1:0] opcode,
  input  tstate_e             step,
  input  logic                flag_c,
  input  logic                flag_z,
  output cw_t                 cw,
  output logic                last_step
);

  logic [3:0] op;
  tstate_e    last_t;

  assign op = 4'(opcode);

  always_comb begin
    cw = CW_IDLE;
    case (step)
      T0: cw = CW_IDLE | cw_bit(CW_CO) | cw_bit(CW_MI);
      T1: cw = CW_IDLE | cw_bit(CW_RO) | cw_bit(CW_II) | cw_bit(CW_CE);
      T2: begin
        case (op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA:
            cw = CW_IDLE | cw_bit(CW_IO) | cw_bit(CW_MI);
          OP_LDI: cw = CW_IDLE | cw_bit(CW_IO) | cw_bit(CW_AI);
          OP_JMP: cw = CW_IDLE | cw_bit(CW_IO) | cw_bit(CW_J);
          OP_JC: begin
            if (flag_c) cw = CW_IDLE | cw_bit(CW_IO) | cw_bit(CW_J);
          end
          OP_JZ: begin
            if (flag_z) cw = CW_IDLE | cw_bit(CW_IO) | cw_bit(CW_J);
          end
          OP_OUT: cw = CW_IDLE | cw_bit(CW_AO) | cw_bit(CW_OI);
          OP_HLT: cw = CW_IDLE | cw_bit(CW_HLT);
          default: ;
        endcase
      end
      T3: begin
        case (op)
          OP_LDA:         cw = CW_IDLE | cw_bit(CW_RO) | cw_bit(CW_AI);
          OP_ADD, OP_SUB: cw = CW_IDLE | cw_bit(CW_RO) | cw_bit(CW_BI);
          OP_STA:         cw = CW_IDLE | cw_bit(CW_AO) | cw_bit(CW_RI);
          default: ;
        endcase
      end
      T4: begin
        // alu_sub rides in the same word as alu_en=0 so the subtract is
        // stable for the whole cycle the ALU drives the bus.
        case (op)
          OP_ADD: cw = (CW_IDLE & ~cw_bit(CW_ALU_EN)) | cw_bit(CW_AI) | cw_bit(CW_FI);
          OP_SUB: cw = (CW_IDLE & ~cw_bit(CW_ALU_EN)) | cw_bit(CW_AI) | cw_bit(CW_FI)
                       | cw_bit(CW_ALU_SUB);
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Last step of the instruction. Conditional jumps always end at T2,
  // whether taken or not; NOP and undefined opcodes run the full count.
  always_comb begin
    last_t = tstate_e'(3'(STEPS - 1));
    if (EARLY_END) begin
      case (op)
        OP_LDA, OP_STA: last_t = T3;
        OP_ADD, OP_SUB: last_t = T4;
        OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: last_t = T2;
        default: ;
      endcase
    end
  end

  assign last_step = (step == last_t);

endmodule

// File: rtl/sap_control_sequencer.sv
// Purpose: SAP controller-sequencer; T-state counter, halt latch and carry/zero flags around the microcode ROM.
// Latency: control lines are combinational from registered state; flags update on the edge ending an fi cycle.
// Backpressure: none; advances every clock until halted, only rst leaves halt.
//  Ports: clk, rst (async, active-high); bus (master modport) carries opcode/ALU status in,
//  all control lines, flag_c/flag_z and debug step out.
module sap_control_sequencer
  import sap_ctrl_pkg::*;
#(
  parameter int OPCODE_W  = 4,
  parameter int STEPS     = 5,
  parameter bit EARLY_END = 1'b1
) (
  input logic                    clk,
  input logic                    rst,
  sap_control_sequencer_if.master bus
);

  tstate_e step_q, step_d;
  logic    halted_q, halted_d;
  logic    flag_c_q, flag_c_d;
  logic    flag_z_q, flag_z_d;
  cw_t     rom_cw;
  logic    rom_last;
  cw_t     cw_out;

  sap_microcode_rom #(
    .OPCODE_W  (OPCODE_W),
    .STEPS     (STEPS),
    .EARLY_END (EARLY_END)
  ) u_rom (
    .opcode    (bus.opcode),
    .step      (step_q),
    .flag_c    (flag_c_q),
    .flag_z    (flag_z_q),
    .cw        (rom_cw),
    .last_step (rom_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q   <= T0;
      halted_q <= 1'b0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
    end
  end

  // Next state. HLT's T2 edge latches halt and leaves step parked at T2.
  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;
    if (!halted_q) begin
      if (rom_cw[CW_HLT]) begin
        halted_d = 1'b1;
      end else if (rom_last) begin
        step_d = T0;
      end else begin
        step_d = tstate_e'(step_q + 3'd1);
      end
      if (rom_cw[CW_FI]) begin
        flag_c_d = bus.alu_carry;
        flag_z_d = bus.alu_zero;
      end
    end
  end

  // Reset must idle the lines immediately: step=0 would otherwise decode
  // as a T0 fetch while rst is still held.
  always_comb begin
    cw_out = rom_cw;
    if (rst) begin
      cw_out = CW_IDLE;
    end else if (halted_q) begin
      cw_out = CW_IDLE | cw_bit(CW_HLT);
    end
  end

  assign bus.hlt     = cw_out[CW_HLT];
  assign bus.mi      = cw_out[CW_MI];
  assign bus.ri      = cw_out[CW_RI];
  assign bus.ro      = cw_out[CW_RO];
  assign bus.ii      = cw_out[CW_II];
  assign bus.io      = cw_out[CW_IO];
  assign bus.ai      = cw_out[CW_AI];
  assign bus.ao      = cw_out[CW_AO];
  assign bus.bi      = cw_out[CW_BI];
  assign bus.alu_en  = cw_out[CW_ALU_EN];
  assign bus.alu_sub = cw_out[CW_ALU_SUB];
  assign bus.oi      = cw_out[CW_OI];
  assign bus.ce      = cw_out[CW_CE];
  assign bus.co      = cw_out[CW_CO];
  assign bus.j       = cw_out[CW_J];
  assign bus.fi      = cw_out[CW_FI];
  assign bus.flag_c  = flag_c_q;
  assign bus.flag_z  = flag_z_q;
  assign bus.step    = step_q;

endmodule
